setting_editor_module: RTL and testbench
========================================

// Module: setting_editor_module
// PURPOSE
//  Parametrised settings editor for SET_MODE. Edits the clean-reminder time (s) and gesture time (s).
//  Changes go into shadow copies and reach the committed outputs only on confirm.
//  Adds hold-to-auto-repeat, optional wrap-around, confirm/cancel and a dirty flag.
//  Sits between the keyboard decoder and the mode FSM / 8-digit display mux.
// PARAMETERS
//  MODE_W        4          width of current_mode
//  SET_CODE      `SET_MODE  mode code that enables editing
//  TIME_W        19         width of time registers (99:59:59 = 359999 fits)
//  TIME_MIN      1          lower time bound (s)
//  TIME_MAX      359999     upper time bound (s)
//  TIME_DEF      36000      time reset value (10:00:00)
//  GEST_W        4          width of gesture registers
//  GEST_MIN      1          lower gesture bound (s)
//  GEST_MAX      9          upper gesture bound (s)
//  GEST_DEF      5          gesture reset value (s)
//  REPEAT_DELAY  50000000   cycles a key is held before the first repeat
//  REPEAT_PERIOD 10000000   cycles between subsequent repeats
//  WRAP          0          0 = saturate at bounds; 1 = step past a bound wraps to the opposite bound
//  AUTO_COMMIT   1          1 = leaving SET_CODE commits the shadow; 0 = discards it
// PORTS
//  clk               in   1       system clock
//  rstn              in   1       reset, asynchronous, active-low
//  current_mode      in   MODE_W  current system mode
//  keys              in   8       debounced levels {tg,tt,td,te,ts,tw,ta,tq}
//  key_ok            in   1       confirm key level
//  key_cancel        in   1       cancel key level
//  clean_remind_time out  TIME_W  committed reminder time (s)
//  gesture_time      out  GEST_W  committed gesture time (s)
//  numbers           out  32      8 BCD digits HHMMSS,GG
//  dirty             out  1       1 in SET_CODE while shadow != committed
// BEHAVIOUR
//  - Reset: committed and shadow = TIME_DEF/GEST_DEF, state IDLE, key history 0, dirty 0, hold counter 0.
//  - Key map, same step for inc/dec: tq/ta +/-3600; tw/ts +/-60; te/td +/-1 on time; tt/tg +/-1 on gesture.
//  - Valid key: keys is exactly one-hot. 0 bits or >=2 bits = no key, and the repeat machine is cleared.
//  - FSM states: IDLE, EDIT, HOLD, REPEAT.
//    - IDLE -> EDIT when current_mode==SET_CODE; shadow <= committed on that edge.
//    - EDIT -> HOLD on a press edge (valid key != last sampled keys). The step is applied on that same edge.
//    - HOLD: counter counts cycles while the same key is held. At REPEAT_DELAY-1: apply step, clear counter, go to REPEAT.
//    - REPEAT: apply step every REPEAT_PERIOD cycles. Key release or change -> EDIT; a new valid key is a new press edge.
//    - Any state -> IDLE when mode != SET_CODE. Shadow is committed if AUTO_COMMIT=1, else discarded. History cleared.
//  - Step arithmetic is done one bit wider than the register; no intermediate underflow.
//    - inc: v+s <= MAX ? v+s : (WRAP ? MIN : MAX).
//    - dec: v >= MIN+s ? v-s : (WRAP ? MAX : MIN).
//  - key_ok rising edge: committed <= shadow. key_cancel rising edge: shadow <= committed.
//    - Both edges in one cycle: neither action.
//    - ok/cancel edge with a key edge in the same cycle: the key is ignored that cycle.
//  - Latency: shadow/committed change on the clock edge that first samples the press, repeat or ok. numbers is combinational from the registers.
//  - numbers shows shadow in SET_CODE, committed otherwise. Digits: time/3600 (2 digits), (time%3600)/60, time%60, gesture.
//  - Async reset mid-repeat: everything returns to reset values immediately; no step occurs after reset release until a new press edge.
// STRUCTURE
//  - Shared header parameters.vh: SET_MODE code, bound/default constants, key index defines.
//  - Sub-module sec_to_bcd_digits: combinational, TIME_W seconds -> 6 BCD digits. Instantiated once for the time digits.
//  - Hold counter width = $clog2(REPEAT_DELAY+1).
// TESTING  (bench overrides REPEAT_DELAY=8, REPEAT_PERIOD=3)
//  1. Reset release, mode IDLE -> clean=36000, gesture=5, numbers=32'h1000_0005, dirty=0.
//  2. SET, tq 1 cycle, ok pulse -> dirty=1 before ok; clean=39600, numbers=32'h1100_0005 after ok; dirty=0.
//  3. SET, te held 20 cycles from 10:00:00 -> steps at cycles 0,8,11,14,17; shadow=36005; no step after release.
//  4. Bounds: shadow 359999 + tq (WRAP=0) -> 359999; WRAP=1 + te -> 1; gesture 1 + tg (WRAP=0) -> 1.
//  5. Edits then cancel -> shadow=committed. AUTO_COMMIT=0: edit, leave SET -> clean unchanged; re-enter shows committed.
//  6. tq+tw together -> no change. ok+cancel same cycle -> no change. rstn low mid-REPEAT -> defaults, IDLE.

Source files
------------

// File: rtl/setting_editor_module_pkg.sv
`default_nettype none
// ============================================================================
// Module      : setting_editor_module_pkg
// Description : Shared constants, key indices, FSM state type and helpers for
//               the settings editor.
// Revision    : 1.0 - initial release
// ============================================================================
package setting_editor_module_pkg;

  // Mode code under which the editor accepts keys
  localparam logic [3:0] SET_MODE = 4'd3;

  // Bounds and reset values (seconds)
  localparam int TIME_MIN_S = 1;
  localparam int TIME_MAX_S = 359999;
  localparam int TIME_DEF_S = 36000;
  localparam int GEST_MIN_S = 1;
  localparam int GEST_MAX_S = 9;
  localparam int GEST_DEF_S = 5;

  // Bit positions inside keys = {tg,tt,td,te,ts,tw,ta,tq}
  localparam logic [2:0] KEY_TQ = 3'd0;
  localparam logic [2:0] KEY_TA = 3'd1;
  localparam logic [2:0] KEY_TW = 3'd2;
  localparam logic [2:0] KEY_TS = 3'd3;
  localparam logic [2:0] KEY_TE = 3'd4;
  localparam logic [2:0] KEY_TD = 3'd5;
  localparam logic [2:0] KEY_TT = 3'd6;
  localparam logic [2:0] KEY_TG = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_REPEAT = 2'd3
  } edit_state_e;

  // True when exactly one key bit is set
  function automatic logic is_one_hot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/setting_editor_module_if.sv
`default_nettype none
// ============================================================================
// Module      : setting_editor_module_if
// Description : Keypad/mode inputs and committed/display outputs of the
//               settings editor. master = keypad/mode side, slave = editor.
// Revision    : 1.0 - initial release
// ============================================================================
interface setting_editor_module_if #(
  parameter int MODE_W = 4,
  parameter int TIME_W = 19,
  parameter int GEST_W = 4
);
  logic [MODE_W-1:0] current_mode;
  logic [7:0]        keys;
  logic              key_ok;
  logic              key_cancel;
  logic [TIME_W-1:0] clean_remind_time;
  logic [GEST_W-1:0] gesture_time;
  logic [31:0]       numbers;
  logic              dirty;

  modport master (
    output current_mode, keys, key_ok, key_cancel,
    input  clean_remind_time, gesture_time, numbers, dirty
  );

  modport slave (
    input  current_mode, keys, key_ok, key_cancel,
    output clean_remind_time, gesture_time, numbers, dirty
  );
endinterface
`default_nettype wire

// File: rtl/setting_editor_module_sec_to_bcd_digits.sv
`default_nettype none
// ============================================================================
// Module      : sec_to_bcd_digits
// Description : Combinational seconds -> HHMMSS as six BCD digits.
// Revision    : 1.0 - initial release
// ============================================================================
module sec_to_bcd_digits #(
  parameter int TIME_W = 19
) (
  input  logic [TIME_W-1:0] sec_i,
  output logic [23:0]       bcd_o
);

  logic [31:0] w_sec;
  logic [31:0] w_hrs;
  logic [31:0] w_min;
  logic [31:0] w_s;

  // Split seconds into hours/minutes/seconds, then each into tens/ones
  always_comb begin
    w_sec = 32'(sec_i);
    w_hrs = w_sec / 32'd3600;
    w_min = (w_sec % 32'd3600) / 32'd60;
    w_s   = w_sec % 32'd60;
    bcd_o = {4'((w_hrs / 32'd10) % 32'd10), 4'(w_hrs % 32'd10),
             4'(w_min / 32'd10),            4'(w_min % 32'd10),
             4'(w_s / 32'd10),              4'(w_s % 32'd10)};
  end

endmodule
`default_nettype wire

// File: rtl/setting_editor_module.sv
`default_nettype none
// ============================================================================
// Module      : setting_editor_module
// Description : Shadow/commit editor for clean-reminder time and gesture time
//               with hold-to-repeat, optional wrap, confirm/cancel and dirty.
// Revision    : 1.0 - initial release
// ============================================================================
module setting_editor_module
  import setting_editor_module_pkg::*;
#(
  parameter int                MODE_W        = 4,
  parameter logic [MODE_W-1:0] SET_CODE      = SET_MODE,
  parameter int                TIME_W        = 19,
  parameter int                TIME_MIN      = TIME_MIN_S,
  parameter int                TIME_MAX      = TIME_MAX_S,
  parameter int                TIME_DEF      = TIME_DEF_S,
  parameter int                GEST_W        = 4,
  parameter int                GEST_MIN      = GEST_MIN_S,
  parameter int                GEST_MAX      = GEST_MAX_S,
  parameter int                GEST_DEF      = GEST_DEF_S,
  parameter int                REPEAT_DELAY  = 50000000,
  parameter int                REPEAT_PERIOD = 10000000,
  parameter int                WRAP          = 0,
  parameter int                AUTO_COMMIT   = 1
) (
  input logic                     clk,
  input logic                     rstn,
  setting_editor_module_if.slave  bus
);

  typedef logic [TIME_W-1:0] time_t;
  typedef logic [TIME_W:0]   time_x_t;
  typedef logic [GEST_W-1:0] gest_t;
  typedef logic [GEST_W:0]   gest_x_t;

  localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam time_x_t C_T_MIN  = time_x_t'(TIME_MIN);
  localparam time_x_t C_T_MAX  = time_x_t'(TIME_MAX);
  localparam gest_x_t C_G_MIN  = gest_x_t'(GEST_MIN);
  localparam gest_x_t C_G_MAX  = gest_x_t'(GEST_MAX);
  localparam time_x_t C_STEP_H = time_x_t'(3600);
  localparam time_x_t C_STEP_M = time_x_t'(60);
  localparam time_x_t C_STEP_S = time_x_t'(1);
  localparam gest_x_t C_STEP_G = gest_x_t'(1);
  localparam cnt_t    C_DELAY_LAST  = cnt_t'(REPEAT_DELAY - 1);
  localparam cnt_t    C_PERIOD_LAST = cnt_t'(REPEAT_PERIOD - 1);

  // One-bit-wider step so neither overflow nor underflow can alias
  function automatic time_t step_time(input time_t v, input time_x_t s, input logic inc);
    time_x_t vx;
    time_t   r;
    vx = {1'b0, v};
    if (inc) begin
      if (vx + s <= C_T_MAX) r = time_t'(vx + s);
      else                   r = (WRAP != 0) ? time_t'(C_T_MIN) : time_t'(C_T_MAX);
    end else begin
      if (vx >= C_T_MIN + s) r = time_t'(vx - s);
      else                   r = (WRAP != 0) ? time_t'(C_T_MAX) : time_t'(C_T_MIN);
    end
    return r;
  endfunction

  function automatic gest_t step_gest(input gest_t v, input logic inc);
    gest_x_t vx;
    gest_t   r;
    vx = {1'b0, v};
    if (inc) begin
      if (vx + C_STEP_G <= C_G_MAX) r = gest_t'(vx + C_STEP_G);
      else                          r = (WRAP != 0) ? gest_t'(C_G_MIN) : gest_t'(C_G_MAX);
    end else begin
      if (vx >= C_G_MIN + C_STEP_G) r = gest_t'(vx - C_STEP_G);
      else                          r = (WRAP != 0) ? gest_t'(C_G_MAX) : gest_t'(C_G_MIN);
    end
    return r;
  endfunction

  edit_state_e state_q, state_d;
  time_t       clean_q, clean_d;
  gest_t       gest_q, gest_d;
  time_t       sh_time_q, sh_time_d;
  gest_t       sh_gest_q, sh_gest_d;
  logic [7:0]  keys_q, keys_d;
  logic        ok_q, ok_d;
  logic        cancel_q, cancel_d;
  cnt_t        cnt_q, cnt_d;

  logic        w_in_set;
  logic        w_valid;
  logic        w_ok_edge;
  logic        w_cancel_edge;
  logic        w_step;
  logic [2:0]  w_key_idx;
  time_t       w_sh_time_step;
  gest_t       w_sh_gest_step;
  time_t       w_disp_time;
  gest_t       w_disp_gest;
  logic [7:0]  w_gest8;
  logic [23:0] w_time_bcd;

  assign w_in_set      = (bus.current_mode == SET_CODE);
  assign w_valid       = is_one_hot(bus.keys);
  assign w_ok_edge     = bus.key_ok & ~ok_q;
  assign w_cancel_edge = bus.key_cancel & ~cancel_q;

  // Index of the pressed key (meaningful only when keys is one-hot)
  always_comb begin
    w_key_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.keys[i]) w_key_idx = 3'(i);
    end
  end

  // Shadow values after one step of the currently pressed key
  always_comb begin
    w_sh_time_step = sh_time_q;
    w_sh_gest_step = sh_gest_q;
    case (w_key_idx)
      KEY_TQ:  w_sh_time_step = step_time(sh_time_q, C_STEP_H, 1'b1);
      KEY_TA:  w_sh_time_step = step_time(sh_time_q, C_STEP_H, 1'b0);
      KEY_TW:  w_sh_time_step = step_time(sh_time_q, C_STEP_M, 1'b1);
      KEY_TS:  w_sh_time_step = step_time(sh_time_q, C_STEP_M, 1'b0);
      KEY_TE:  w_sh_time_step = step_time(sh_time_q, C_STEP_S, 1'b1);
      KEY_TD:  w_sh_time_step = step_time(sh_time_q, C_STEP_S, 1'b0);
      KEY_TT:  w_sh_gest_step = step_gest(sh_gest_q, 1'b1);
      KEY_TG:  w_sh_gest_step = step_gest(sh_gest_q, 1'b0);
      default: ;
    endcase
  end

  // Next-state: session entry/exit, press/hold/repeat timing, ok/cancel
  always_comb begin
    state_d   = state_q;
    clean_d   = clean_q;
    gest_d    = gest_q;
    sh_time_d = sh_time_q;
    sh_gest_d = sh_gest_q;
    keys_d    = keys_q;
    cnt_d     = cnt_q;
    ok_d      = bus.key_ok;
    cancel_d  = bus.key_cancel;
    w_step    = 1'b0;

    if (!w_in_set) begin
      state_d = ST_IDLE;
      keys_d  = 8'd0;
      cnt_d   = '0;
      if (state_q != ST_IDLE) begin
        if (AUTO_COMMIT != 0) begin
          clean_d = sh_time_q;
          gest_d  = sh_gest_q;
        end else begin
          sh_time_d = clean_q;
          sh_gest_d = gest_q;
        end
      end
    end else if (state_q == ST_IDLE) begin
      state_d   = ST_EDIT;
      sh_time_d = clean_q;
      sh_gest_d = gest_q;
      keys_d    = 8'd0;
      cnt_d     = '0;
    end else begin
      keys_d = bus.keys;
      if (!w_valid) begin
        state_d = ST_EDIT;
        cnt_d   = '0;
      end else if (bus.keys != keys_q) begin
        w_step  = 1'b1;
        state_d = ST_HOLD;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_HOLD: begin
            if (cnt_q == C_DELAY_LAST) begin
              w_step  = 1'b1;
              cnt_d   = '0;
              state_d = ST_REPEAT;
            end else begin
              cnt_d = cnt_q + cnt_t'(1);
            end
          end
          ST_REPEAT: begin
            if (cnt_q == C_PERIOD_LAST) begin
              w_step = 1'b1;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + cnt_t'(1);
            end
          end
          default: ;
        endcase
      end

      // ok/cancel take priority over a key step; both together cancel out
      if (w_ok_edge && !w_cancel_edge) begin
        clean_d = sh_time_q;
        gest_d  = sh_gest_q;
      end else if (w_cancel_edge && !w_ok_edge) begin
        sh_time_d = clean_q;
        sh_gest_d = gest_q;
      end else if (!w_ok_edge && !w_cancel_edge && w_step) begin
        sh_time_d = w_sh_time_step;
        sh_gest_d = w_sh_gest_step;
      end
    end
  end

  // Registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      clean_q   <= time_t'(TIME_DEF);
      gest_q    <= gest_t'(GEST_DEF);
      sh_time_q <= time_t'(TIME_DEF);
      sh_gest_q <= gest_t'(GEST_DEF);
      keys_q    <= 8'd0;
      ok_q      <= 1'b0;
      cancel_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      clean_q   <= clean_d;
      gest_q    <= gest_d;
      sh_time_q <= sh_time_d;
      sh_gest_q <= sh_gest_d;
      keys_q    <= keys_d;
      ok_q      <= ok_d;
      cancel_q  <= cancel_d;
      cnt_q     <= cnt_d;
    end
  end

  // Display shows the shadow while editing, the committed values otherwise
  assign w_disp_time = w_in_set ? sh_time_q : clean_q;
  assign w_disp_gest = w_in_set ? sh_gest_q : gest_q;
  assign w_gest8     = 8'(w_disp_gest);

  sec_to_bcd_digits #(
    .TIME_W (TIME_W)
  ) u_time_bcd (
    .sec_i (w_disp_time),
    .bcd_o (w_time_bcd)
  );

  assign bus.numbers           = {w_time_bcd, 4'(w_gest8 / 8'd10), 4'(w_gest8 % 8'd10)};
  assign bus.clean_remind_time = clean_q;
  assign bus.gesture_time      = gest_q;
  assign bus.dirty             = w_in_set && ((sh_time_q != clean_q) || (sh_gest_q != gest_q));

endmodule
`default_nettype wire

// File: tb/tb_setting_editor_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_setting_editor_module
// Description : Three editor instances (saturate/commit, wrap/commit,
//               saturate/discard) driven by shared stimulus and compared
//               every cycle against a per-instance behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_setting_editor_module;
  import setting_editor_module_pkg::*;

  localparam int N      = 3;
  localparam int DELAY  = 8;
  localparam int PERIOD = 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] mode = 4'd0;
  logic [7:0] keys = 8'd0;
  logic       ok = 1'b0;
  logic       cancel = 1'b0;

  logic [18:0] o_clean [N];
  logic [3:0]  o_gest  [N];
  logic [31:0] o_num   [N];
  logic        o_dirty [N];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    setting_editor_module_if #(.MODE_W(4), .TIME_W(19), .GEST_W(4)) ifc ();
    assign ifc.current_mode = mode;
    assign ifc.keys         = keys;
    assign ifc.key_ok       = ok;
    assign ifc.key_cancel   = cancel;
    assign o_clean[g] = ifc.clean_remind_time;
    assign o_gest[g]  = ifc.gesture_time;
    assign o_num[g]   = ifc.numbers;
    assign o_dirty[g] = ifc.dirty;
    setting_editor_module #(
      .REPEAT_DELAY  (DELAY),
      .REPEAT_PERIOD (PERIOD),
      .WRAP          ((g == 1) ? 1 : 0),
      .AUTO_COMMIT   ((g == 2) ? 0 : 1)
    ) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (ifc)
    );
  end

  // ---------------- behavioural model ----------------
  int   m_ct [N];
  int   m_cg [N];
  int   m_st [N];
  int   m_sg [N];
  bit   m_active;
  logic [7:0] m_prev;
  int   m_held;
  bit   m_okp, m_cap;

  function automatic bit cfg_wrap(input int c);
    return c == 1;
  endfunction

  function automatic bit cfg_commit(input int c);
    return c != 2;
  endfunction

  function automatic int bump(input int v, input int s, input bit inc,
                              input int lo, input int hi, input bit wr);
    int r;
    r = inc ? v + s : v - s;
    if (r > hi) return wr ? lo : hi;
    if (r < lo) return wr ? hi : lo;
    return r;
  endfunction

  function automatic logic [31:0] digits(input int t, input int g);
    int h, m, s;
    h = t / 3600;
    m = (t % 3600) / 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(g / 10), 4'(g % 10)};
  endfunction

  task automatic model_update();
    bit ok_e, ca_e, stp;
    int idx, amt;
    if (!rstn) begin
      for (int c = 0; c < N; c++) begin
        m_ct[c] = 36000; m_st[c] = 36000; m_cg[c] = 5; m_sg[c] = 5;
      end
      m_active = 0; m_prev = 8'd0; m_held = 0; m_okp = 0; m_cap = 0;
      return;
    end
    ok_e = ok && !m_okp;
    ca_e = cancel && !m_cap;
    m_okp = ok;
    m_cap = cancel;
    if (mode != SET_MODE) begin
      if (m_active) begin
        for (int c = 0; c < N; c++) begin
          if (cfg_commit(c)) begin m_ct[c] = m_st[c]; m_cg[c] = m_sg[c]; end
          else begin m_st[c] = m_ct[c]; m_sg[c] = m_cg[c]; end
        end
      end
      m_active = 0; m_prev = 8'd0; m_held = 0;
    end else if (!m_active) begin
      m_active = 1; m_prev = 8'd0; m_held = 0;
      for (int c = 0; c < N; c++) begin m_st[c] = m_ct[c]; m_sg[c] = m_cg[c]; end
    end else begin
      stp = 0;
      if ($countones(keys) != 1) m_held = 0;
      else if (keys != m_prev) begin stp = 1; m_held = 0; end
      else begin
        m_held++;
        if (m_held == DELAY || (m_held > DELAY && (m_held - DELAY) % PERIOD == 0)) stp = 1;
      end
      m_prev = keys;
      idx = $clog2(keys);
      amt = (idx < 2) ? 3600 : (idx < 4) ? 60 : 1;
      for (int c = 0; c < N; c++) begin
        if (ok_e && !ca_e) begin m_ct[c] = m_st[c]; m_cg[c] = m_sg[c]; end
        else if (ca_e && !ok_e) begin m_st[c] = m_ct[c]; m_sg[c] = m_cg[c]; end
        else if (!ok_e && !ca_e && stp) begin
          if (idx < 6) m_st[c] = bump(m_st[c], amt, (idx % 2) == 0, 1, 359999, cfg_wrap(c));
          else         m_sg[c] = bump(m_sg[c], 1, idx == 6, 1, 9, cfg_wrap(c));
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      model_update();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all instances against the model
  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        bit in_set;
        in_set = (mode == SET_MODE);
        chk($sformatf("clean[%0d]", c), 32'(o_clean[c]), 32'(m_ct[c]));
        chk($sformatf("gest[%0d]", c), 32'(o_gest[c]), 32'(m_cg[c]));
        chk($sformatf("numbers[%0d]", c), o_num[c],
            in_set ? digits(m_st[c], m_sg[c]) : digits(m_ct[c], m_cg[c]));
        chk($sformatf("dirty[%0d]", c), 32'(o_dirty[c]),
            32'(in_set && (m_st[c] != m_ct[c] || m_sg[c] != m_cg[c])));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [7:0] k);
    keys = k;
    step();
    keys = 8'd0;
    step();
  endtask

  task automatic pulse_ok();
    ok = 1'b1; step(); ok = 1'b0; step();
  endtask

  task automatic pulse_cancel();
    cancel = 1'b1; step(); cancel = 1'b0; step();
  endtask

  int r1, r2;

  initial begin
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    chk("t1 numbers", o_num[0], 32'h1000_0005);
    chk("t1 clean", 32'(o_clean[0]), 32'd36000);
    chk("t1 gest", 32'(o_gest[0]), 32'd5);
    chk("t1 dirty", 32'(o_dirty[0]), 32'd0);

    // confirm one hour step
    mode = SET_MODE; step();
    press(8'h01);
    chk("t2 dirty pre-ok", 32'(o_dirty[0]), 32'd1);
    chk("t2 shadow", o_num[0], 32'h1100_0005);
    pulse_ok();
    chk("t2 clean", 32'(o_clean[0]), 32'd39600);
    chk("t2 numbers", o_num[0], 32'h1100_0005);
    chk("t2 dirty", 32'(o_dirty[0]), 32'd0);

    // back to 10:00:00, then hold te for 20 cycles
    press(8'h02);
    pulse_ok();
    keys = 8'h10; repeat (20) step();
    keys = 8'h00; repeat (5) step();
    chk("t3 repeat", o_num[0], 32'h1000_0505);
    chk("t3 dirty", 32'(o_dirty[0]), 32'd1);
    pulse_cancel();
    chk("t5 cancel", o_num[0], 32'h1000_0005);

    // 90 hour steps: saturate vs wrap
    keys = 8'h01; repeat (273) step();
    keys = 8'h00; step();
    chk("t4 sat max", o_num[0], 32'h9959_5905);
    chk("t4 wrap max", o_num[1], 32'h0000_0105);
    press(8'h20);
    chk("t4 wrap min", o_num[1], 32'h9959_5905);
    press(8'h10);
    chk("t4 wrap te", o_num[1], 32'h0000_0105);
    chk("t4 sat te", o_num[0], 32'h9959_5905);
    press(8'h01);
    chk("t4 sat tq", o_num[0], 32'h9959_5905);
    repeat (5) press(8'h80);
    chk("t4 gest sat", o_num[0] & 32'hFF, 32'h01);
    chk("t4 gest wrap", o_num[1] & 32'hFF, 32'h09);
    pulse_cancel();
    chk("t5 cancel2", o_num[0], 32'h1000_0005);

    // leave SET with an edit pending
    press(8'h01);
    mode = 4'd0; step();
    chk("t5 discard clean", 32'(o_clean[2]), 32'd36000);
    chk("t5 commit clean", 32'(o_clean[0]), 32'd39600);
    chk("t5 discard num", o_num[2], 32'h1000_0005);
    mode = SET_MODE; step();
    chk("t5 reenter disc", o_num[2], 32'h1000_0005);
    chk("t5 reenter comm", o_num[0], 32'h1100_0005);

    // multi-key, ok+cancel together, async reset mid-repeat
    press(8'h05);
    chk("t6 multikey", o_num[0], 32'h1100_0005);
    press(8'h10);
    ok = 1'b1; cancel = 1'b1; step();
    ok = 1'b0; cancel = 1'b0; step();
    chk("t6 okcancel clean", 32'(o_clean[0]), 32'd39600);
    chk("t6 okcancel num", o_num[0], 32'h1100_0105);
    keys = 8'h10; repeat (15) step();
    rstn = 1'b0;
    #1;
    chk("t6 rst clean", 32'(o_clean[0]), 32'd36000);
    chk("t6 rst num", o_num[0], 32'h1000_0005);
    chk("t6 rst dirty", 32'(o_dirty[0]), 32'd0);
    keys = 8'h00; step(); step();
    rstn = 1'b1;
    repeat (6) step();
    chk("t6 post rst", o_num[0], 32'h1000_0005);

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      r1 = $urandom_range(0, 99);
      if (r1 < 3)       mode = 4'($urandom_range(0, 15));
      else if (r1 < 20) mode = SET_MODE;
      r2 = $urandom_range(0, 99);
      if (r2 >= 92 && r2 < 96) keys = 8'h01 << $urandom_range(0, 7);
      else if (r2 >= 96 && r2 < 98) keys = 8'h00;
      else if (r2 >= 98) keys = 8'($urandom_range(0, 255));
      ok     = ($urandom_range(0, 19) == 0);
      cancel = ($urandom_range(0, 24) == 0);
      rstn   = ($urandom_range(0, 599) != 0);
      step();
    end
    rstn = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
